neighbor_announcer: RTL

- Transmit-side counterpart of the router's neighbor controller: periodically emits a 3-flit HELLO beacon advertising this node's ID, sequence number and current neighbor count.
- Sits in packet_controller/router beside the neighbor controller and feeds the router's outbound flit arbiter over a valid/ready handshake.
- Supports an on-demand beacon request, e.g. after a neighbor table change.

---
 rtl/packet_types_pkg.sv | 42 ++++
 rtl/neighbor_announcer_beacon_timer.sv | 29 ++
 rtl/neighbor_announcer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/packet_types_pkg.sv
// Shared HELLO packet definitions: type code, field layout, FSM state type
// and the TAIL checksum builder. The receive-side decode imports this as well.
package packet_types;

  localparam logic [3:0] HELLO_TYPE = 4'h1;

  // Field offsets/widths inside a 32-bit flit
  localparam int TYPE_LSB   = 28;
  localparam int TYPE_W     = 4;
  localparam int NODE_LSB   = 20;
  localparam int NODE_W     = 8;
  localparam int SEQ_LSB    = 12;
  localparam int SEQ_W      = 8;
  localparam int COUNT_LSB  = 24;
  localparam int COUNT_W    = 8;
  localparam int PERIOD_LSB = 0;
  localparam int PERIOD_W   = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2,
    TAIL = 2'd3
  } hello_state_t;

  function automatic logic [31:0] hello_head(input logic [7:0] node_id,
                                             input logic [7:0] seq);
    return {HELLO_TYPE, node_id, seq, 12'h000};
  endfunction

  function automatic logic [31:0] hello_body(input logic [7:0]  count,
                                             input logic [23:0] period);
    return {count, period};
  endfunction

  // TAIL carries a simple XOR checksum over HEAD and BODY
  function automatic logic [31:0] hello_tail(input logic [31:0] head,
                                             input logic [31:0] body);
    return head ^ body;
  endfunction

endpackage

// File: rtl/neighbor_announcer_beacon_timer.sv
// Reload down-counter: counts PERIOD-1..0 while enabled, pulses expire at 0
// and reloads. Held at PERIOD-1 while disabled.
module beacon_timer #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic expire
);

  localparam logic [23:0] RELOAD = 24'(PERIOD - 1);

  logic [23:0] count_r;

  // Down-count while enabled; reload on expiry or while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= RELOAD;
    end else if (!enable || (count_r == 24'd0)) begin
      count_r <= RELOAD;
    end else begin
      count_r <= count_r - 24'd1;
    end
  end

  assign expire = enable & (count_r == 24'd0);

endmodule

// File: rtl/neighbor_announcer.sv
// HELLO beacon generator: emits HEAD/BODY/TAIL flits advertising node ID,
// sequence number and neighbor count, periodically or on request.
module neighbor_announcer
  import packet_types::*;
#(
  parameter int NODE_ID_WIDTH = 8,
  parameter int FLIT_WIDTH    = 32,
  parameter int BEACON_PERIOD = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic                     force_i,
  input  logic [NODE_ID_WIDTH-1:0] node_id_i,
  input  logic [7:0]               neighbor_count_i,
  output logic [FLIT_WIDTH-1:0]    tx_flit_o,
  output logic                     tx_valid_o,
  output logic                     tx_last_o,
  input  logic                     tx_ready_i,
  output logic                     busy_o,
  output logic [7:0]               seq_o
);

  localparam logic [23:0] PERIOD_FIELD = 24'(BEACON_PERIOD);

  hello_state_t state_r, state_n_s;
  logic         pending_r, pending_n_s;
  logic [7:0]   seq_r, seq_n_s;
  logic [7:0]   snap_node_r, snap_count_r, snap_seq_r;
  logic         load_snap_s, expire_s, trigger_s, accept_s;
  logic [31:0]  head_s, body_s, tail_s, flit_s;

  beacon_timer #(.PERIOD(BEACON_PERIOD)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable_i),
    .expire (expire_s)
  );

  assign trigger_s = expire_s | (force_i & enable_i);
  assign accept_s  = (state_r != IDLE) & tx_ready_i;

  // Next-state, pending-request and sequence-number logic
  always_comb begin
    state_n_s   = state_r;
    pending_n_s = pending_r;
    seq_n_s     = seq_r;
    load_snap_s = 1'b0;
    case (state_r)
      IDLE: begin
        pending_n_s = 1'b0;
        if (trigger_s) begin
          state_n_s   = HEAD;
          load_snap_s = 1'b1;
        end else begin
          state_n_s   = IDLE;
        end
      end
      HEAD: begin
        pending_n_s = enable_i & (pending_r | trigger_s);
        if (accept_s) begin
          state_n_s = BODY;
        end else begin
          state_n_s = HEAD;
        end
      end
      BODY: begin
        pending_n_s = enable_i & (pending_r | trigger_s);
        if (accept_s) begin
          state_n_s = TAIL;
        end else begin
          state_n_s = BODY;
        end
      end
      TAIL: begin
        if (accept_s) begin
          seq_n_s     = seq_r + 8'd1;
          pending_n_s = 1'b0;
          // A request that arrives on the accepting edge itself is honoured too
          if (enable_i & (pending_r | trigger_s)) begin
            state_n_s   = HEAD;
            load_snap_s = 1'b1;
          end else begin
            state_n_s   = IDLE;
          end
        end else begin
          pending_n_s = enable_i & (pending_r | trigger_s);
          state_n_s   = TAIL;
        end
      end
      default: begin
        state_n_s   = IDLE;
        pending_n_s = 1'b0;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      pending_r <= 1'b0;
      seq_r     <= 8'd0;
    end else begin
      state_r   <= state_n_s;
      pending_r <= pending_n_s;
      seq_r     <= seq_n_s;
    end
  end

  // Capture packet contents when a beacon starts so mid-packet input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_node_r  <= 8'd0;
      snap_count_r <= 8'd0;
      snap_seq_r   <= 8'd0;
    end else if (load_snap_s) begin
      snap_node_r  <= 8'(node_id_i);
      snap_count_r <= neighbor_count_i;
      snap_seq_r   <= seq_n_s;
    end else begin
      snap_node_r  <= snap_node_r;
      snap_count_r <= snap_count_r;
      snap_seq_r   <= snap_seq_r;
    end
  end

  assign head_s = hello_head(snap_node_r, snap_seq_r);
  assign body_s = hello_body(snap_count_r, PERIOD_FIELD);
  assign tail_s = hello_tail(head_s, body_s);

  // Flit selection from registered state only
  always_comb begin
    flit_s = 32'h0000_0000;
    case (state_r)
      HEAD:    flit_s = head_s;
      BODY:    flit_s = body_s;
      TAIL:    flit_s = tail_s;
      default: flit_s = 32'h0000_0000;
    endcase
  end

  assign tx_flit_o  = FLIT_WIDTH'(flit_s);
  assign tx_valid_o = (state_r != IDLE);
  assign busy_o     = (state_r != IDLE);
  assign tx_last_o  = (state_r == TAIL);
  assign seq_o      = seq_r;

endmodule
